// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared CPU pipeline definitions: hazard sequencer states and the hardwired-zero register.
package cpu_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_t;

    localparam logic [4:0] ZERO_REG = 5'd31;

    // Load-use countdown width; covers LOAD_STALL_CYCLES up to 7.
    localparam int LU_CNT_W = 3;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Hazard inputs from the pipeline registers and stall/flush controls back to them.
interface hazard_stall_ctrl_if #(
    parameter int CNT_W = 16
);

    logic [4:0]       IF_ID_Ra;
    logic [4:0]       IF_ID_Rb;
    logic             IF_ID_UsesRb;
    logic             ID_EX_MemRead;
    logic [4:0]       ID_EX_Rw;
    logic             BrTaken;
    logic             mem_req;
    logic             mem_ready;
    logic             stat_clr;
    logic             PCWrite;
    logic             IF_ID_Write;
    logic             ID_EX_Bubble;
    logic             IF_ID_Flush;
    logic             ID_EX_Flush;
    logic             Freeze;
    logic [CNT_W-1:0] stall_cnt;

    modport slave (
        input  IF_ID_Ra, IF_ID_Rb, IF_ID_UsesRb, ID_EX_MemRead, ID_EX_Rw,
        input  BrTaken, mem_req, mem_ready, stat_clr,
        output PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, ID_EX_Flush,
        output Freeze, stall_cnt
    );

    modport master (
        output IF_ID_Ra, IF_ID_Rb, IF_ID_UsesRb, ID_EX_MemRead, ID_EX_Rw,
        output BrTaken, mem_req, mem_ready, stat_clr,
        input  PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, ID_EX_Flush,
        input  Freeze, stall_cnt
    );

endinterface

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard sequencer: load-use bubbles, taken-branch flushes and data-memory freeze.
//   state    | meaning
//   RUN      | normal issue; a new load-use hazard is checked every cycle
//   LU_STALL | remaining load-use bubbles counted down in r_lu_cnt
//   MEM_WAIT | back end frozen on mem_req; r_pre_state holds RUN or LU_STALL
module hazard_stall_ctrl #(
    parameter int         LOAD_STALL_CYCLES = 1,
    parameter int         CNT_W             = 16,
    parameter logic [4:0] ZERO_REG          = cpu_pkg::ZERO_REG
) (
    input  logic                clk,
    input  logic                reset,
    hazard_stall_ctrl_if.slave  bus
);
    import cpu_pkg::*;

    hz_state_t             r_state;
    hz_state_t             r_pre_state;
    hz_state_t             w_state_nxt;
    hz_state_t             w_pre_nxt;
    hz_state_t             w_eff_state;
    logic [LU_CNT_W-1:0]   r_lu_cnt;
    logic [LU_CNT_W-1:0]   w_lu_cnt_nxt;
    logic                  w_lu_haz;
    logic                  w_mem_wait;
    logic                  w_pc_write;
    logic                  w_if_id_write;
    logic                  w_bubble;
    logic                  w_if_id_flush;
    logic                  w_id_ex_flush;
    logic                  w_freeze;

    assign w_lu_haz = bus.ID_EX_MemRead && (bus.ID_EX_Rw != ZERO_REG) &&
                      ((bus.ID_EX_Rw == bus.IF_ID_Ra) ||
                       (bus.IF_ID_UsesRb && (bus.ID_EX_Rw == bus.IF_ID_Rb)));

    assign w_mem_wait = bus.mem_req && !bus.mem_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= RUN;
            r_pre_state <= RUN;
            r_lu_cnt    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pre_state <= w_pre_nxt;
            r_lu_cnt    <= w_lu_cnt_nxt;
        end
    end

    // MEM_WAIT is transparent once the wait ends: decisions use the pre-wait state.
    always_comb begin
        w_eff_state   = (r_state == MEM_WAIT) ? r_pre_state : r_state;
        w_state_nxt   = RUN;
        w_pre_nxt     = r_pre_state;
        w_lu_cnt_nxt  = r_lu_cnt;
        w_pc_write    = 1'b1;
        w_if_id_write = 1'b1;
        w_bubble      = 1'b0;
        w_if_id_flush = 1'b0;
        w_id_ex_flush = 1'b0;
        w_freeze      = 1'b0;

        if (!reset) begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
        end else if (w_mem_wait) begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_freeze      = 1'b1;
            w_state_nxt   = MEM_WAIT;
            w_pre_nxt     = w_eff_state;
        end else if (bus.BrTaken) begin
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
            w_lu_cnt_nxt  = '0;
            w_state_nxt   = RUN;
        end else if (w_lu_haz || (w_eff_state == LU_STALL)) begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_bubble      = 1'b1;
            if (w_eff_state == LU_STALL) begin
                w_lu_cnt_nxt = r_lu_cnt - LU_CNT_W'(1);
                w_state_nxt  = (r_lu_cnt == LU_CNT_W'(1)) ? RUN : LU_STALL;
            end else if (LOAD_STALL_CYCLES > 1) begin
                w_lu_cnt_nxt = LU_CNT_W'(LOAD_STALL_CYCLES - 1);
                w_state_nxt  = LU_STALL;
            end
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (reset),
        .i_clr (bus.stat_clr),
        .i_inc (!w_pc_write),
        .o_cnt (bus.stall_cnt)
    );

    assign bus.PCWrite      = w_pc_write;
    assign bus.IF_ID_Write  = w_if_id_write;
    assign bus.ID_EX_Bubble = w_bubble;
    assign bus.IF_ID_Flush  = w_if_id_flush;
    assign bus.ID_EX_Flush  = w_id_ex_flush;
    assign bus.Freeze       = w_freeze;

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline hazard sequencer for the 5-stage CPU. It sits beside the forwarding unit and covers the hazards forwarding cannot resolve.
- Handled cases: load-use stalls (bubble insertion), taken-branch flushes, and data-memory wait states via a req/ready handshake.
- Drives PC and IF/ID write enables, ID/EX bubble, IF/ID and ID/EX flush, and a back-end freeze.
- Keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
- LOAD_STALL_CYCLES, 1, number of bubbles inserted per load-use hazard (1..7).
- CNT_W, 16, width of the stall-cycle counter.
- ZERO_REG, 5'd31, hardwired-zero register index; it never creates a hazard.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- IF_ID_Ra  in  5  first source register of the instruction in ID.
- IF_ID_Rb  in  5  second source register of the instruction in ID.
- IF_ID_UsesRb  in  1  the instruction in ID actually reads Rb.
- ID_EX_MemRead  in  1  the instruction in EX is a load.
- ID_EX_Rw  in  5  destination register of the instruction in EX.
- BrTaken  in  1  branch in EX resolved as taken.
- mem_req  in  1  the EX/MEM instruction accesses data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- stat_clr  in  1  synchronous clear of stall_cnt.
- PCWrite  out  1  PC update enable.
- IF_ID_Write  out  1  IF/ID register enable.
- ID_EX_Bubble  out  1  force control signals to zero into ID/EX.
- IF_ID_Flush  out  1  clear IF/ID.
- ID_EX_Flush  out  1  clear ID/EX.
- Freeze  out  1  hold EX/MEM and MEM/WB.
- stall_cnt  out  CNT_W  saturating count of cycles with PCWrite=0.

Behaviour:
- Clocking and output style:
  - One clock. Reset is asynchronous and active-low.
  - State registered. Outputs are Mealy combinational from state plus inputs, so a stall takes effect in the same cycle the hazard is detected.
- Load-use hazard: lu_haz = ID_EX_MemRead & (ID_EX_Rw != ZERO_REG) & ((ID_EX_Rw == IF_ID_Ra) | (IF_ID_UsesRb & ID_EX_Rw == IF_ID_Rb)).
- States: RUN, LU_STALL, MEM_WAIT.
- Default outputs: PCWrite=1, IF_ID_Write=1, all others 0.
- Evaluation priority, applied in RUN and LU_STALL:
  1. Memory wait: mem_req & !mem_ready -> PCWrite=0, IF_ID_Write=0, Freeze=1, no bubble, no flush. Next state MEM_WAIT; the LU counter is held.
  2. BrTaken -> IF_ID_Flush=1, ID_EX_Flush=1, PCWrite=1. Any pending load-use stall is cancelled. Next state RUN.
  3. Load-use, or state LU_STALL -> PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1.
- Load-use state transitions:
  - From RUN with lu_haz: if LOAD_STALL_CYCLES==1, stay in RUN. Otherwise load lu_cnt=LOAD_STALL_CYCLES-1 and go to LU_STALL.
  - In LU_STALL: decrement lu_cnt each cycle; go to RUN when lu_cnt reaches 1 and is decremented.
- MEM_WAIT:
  - While mem_ready=0: hold the freeze outputs.
  - In the cycle mem_ready=1: outputs and next state are evaluated exactly as in the pre-wait state (RUN, or LU_STALL with the held lu_cnt).
  - If mem_req drops without mem_ready, return to the pre-wait state.
- stall_cnt:
  - Increments on every clock edge where PCWrite=0 and reset is high; saturates at all-ones.
  - stat_clr has priority over the increment.
- While reset is low:
  - State RUN, lu_cnt=0, stall_cnt=0.
  - PCWrite=0, IF_ID_Write=0, Bubble=0, both flushes=0, Freeze=0.
- On reset release: RUN defaults from the first cycle. Reset mid-stall aborts the stall with no residual bubble.

Decomposition:
- Shared package cpu_pkg: the state enum hz_state_t {RUN, LU_STALL, MEM_WAIT} and the ZERO_REG constant. The forwarding unit uses ZERO_REG as well.
- One sub-module, sat_counter (width parameter, clr and inc inputs), used for stall_cnt.
- Hazard compare and FSM stay in the top module.

Test Plan:
- ID_EX_MemRead=1, ID_EX_Rw=3, IF_ID_Ra=3, LOAD_STALL_CYCLES=1 -> one cycle with PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, then defaults; stall_cnt=1.
- Same compare with Rw=31, and separately Rb match with IF_ID_UsesRb=0 -> no stall, defaults throughout.
- LOAD_STALL_CYCLES=3 hazard, with BrTaken=1 in the 2nd stall cycle -> that cycle IF_ID_Flush=ID_EX_Flush=1, PCWrite=1; next cycle RUN defaults.
- mem_req=1 with mem_ready low for 4 cycles -> Freeze=1 and PCWrite=0 for 4 cycles; cycle 5 (mem_ready=1) returns to defaults; stall_cnt=4.
- mem wait starting in LU_STALL (LOAD_STALL_CYCLES=2) -> the remaining bubble is issued after mem_ready, with total bubbles=2.
- reset driven low in MEM_WAIT -> outputs immediately at reset values, stall_cnt=0; after release, RUN defaults. Also drive 2^CNT_W+5 stall cycles -> stall_cnt saturates at all-ones; stat_clr -> 0.
